unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

- Shares one single-port unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage).
- Arbitrates the two requesters, sequences each access with a request/ready handshake, and returns read data in per-port holding registers.
- Drives one global `stall` that freezes PC and all pipeline registers until every pending request of the current cycle is served.
- Includes a watchdog so a missing `mem_ready` cannot hang the core.

## Interface

Parameters:
- `ADDR_WIDTH`, 32: address width of both ports and memory.
- `DATA_WIDTH`, 32: data width.
- `TIMEOUT`, 16: BUSY cycles without `mem_ready` before an access is aborted; ≥2.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req`  in  1  fetch request, level; held while `stall`=1.
- `if_addr`  in  ADDR_WIDTH  fetch address.
- `if_rdata`  out  DATA_WIDTH  registered fetched word.
- `if_valid`  out  1  fetch served for current pipeline cycle (`if_served` flag).
- `dm_req`  in  1  data request, level; held while `stall`=1.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  ADDR_WIDTH  data address.
- `dm_wdata`  in  DATA_WIDTH  write data.
- `dm_rdata`  out  DATA_WIDTH  registered load data.
- `dm_valid`  out  1  data access served (`dm_served` flag).
- `stall`  out  1  combinational: `(if_req & ~if_served) | (dm_req & ~dm_served)`.
- `mem_req`  out  1  memory access in progress.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_WIDTH  latched access address.
- `mem_wdata`  out  DATA_WIDTH  latched write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid with `mem_ready`.
- `mem_ready`  in  1  memory completes current access this cycle.
- `timeout_err`  out  1  sticky watchdog error flag.

## Operation

- States: IDLE, BUSY_DM, BUSY_IF.
- IDLE grant:
  - Priority to the data port (older instruction).
  - `dm_req & ~dm_served` → BUSY_DM; else `if_req & ~if_served` → BUSY_IF; else stay.
  - On grant, latch address, `dm_we`, and `dm_wdata`. Requester inputs are ignored until the next grant.
- BUSY_x:
  - `mem_req`=1.
  - `mem_we` = latched we in BUSY_DM; always 0 in BUSY_IF.
  - `mem_addr`/`mem_wdata` come from the latches.
  - Watchdog counter increments each BUSY cycle.
- Completion (BUSY_x with `mem_ready`=1):
  - Set `x_served`.
  - For reads, capture `mem_rdata` into `x_rdata`; `dm_rdata` is unchanged on writes.
  - Clear counter; → IDLE.
- Timeout (counter = TIMEOUT-1 and `mem_ready`=0):
  - Set `timeout_err`.
  - Set `x_served` with `x_rdata` = 0 (`dm_rdata` unchanged on write abort).
  - → IDLE.
  - `mem_ready` in the same cycle wins: normal completion, no error.
- Flag clear: on any edge where `stall`=0, clear both served flags; the pipeline advances on that edge. A request with its flag set is never re-granted, so a held `dm_req` cannot starve `if_req`.
- `timeout_err` clears only on `rst`.
- Outside BUSY: `mem_req`=0 and `mem_we`=0; `mem_addr`/`mem_wdata` hold last values.

## Timing

- Reset values:
  - State IDLE, counter 0, flags 0.
  - `if_rdata`=`dm_rdata`=0.
  - `mem_req`=`mem_we`=0, `mem_addr`=`mem_wdata`=0, `timeout_err`=0.
  - `stall` follows its equation, so it is 1 during reset if a request is high.
- Reset mid-access: abandon it; `mem_req` low from the cycle after the reset edge; no data captured.
- Single access, `mem_ready` in the first BUSY cycle:
  - Cycle 0 (IDLE): request seen, `stall`=1.
  - Cycle 1: BUSY, `mem_req`=1.
  - Cycle 2: served, `stall`=0, data valid.
  - Edge ending cycle 2: flags clear.
  - Minimum 2 stall cycles; each extra memory wait cycle adds one.
- Both requests in cycle 0: BUSY_DM in cycle 1, IDLE with DM served in cycle 2, BUSY_IF in cycle 3, both served and `stall`=0 in cycle 4.
- `x_rdata` stays stable from its served cycle until the next capture on the same port.
- Requests rising in a cycle where `stall`=0 and the flags are set: not granted that cycle; evaluated next cycle after the flags clear.

## Test plan

- **Reset:** `rst`=1 for 2 cycles with `if_req`=1 → all registered outputs 0, `stall`=1. After release, fetch of 0x0000_0000 completes per the single-access timing.
- **Fetch only:** `if_addr`=0x40, memory returns 0x2010_0005 with ready in the first BUSY cycle → `if_rdata`=0x2010_0005 and `if_valid`=1 in cycle 2; `stall` high exactly cycles 0–1.
- **Simultaneous requests:** `dm_req` (read 0x100 → 0xDEAD_BEEF) and `if_req` (0x44 → 0x8C22_0000) in cycle 0 → DM served first (cycle 2), IF in cycle 4; `stall` deasserts cycle 4; no second DM grant.
- **Store with wait states:** `dm_we`=1, addr 0x200, data 0x1234_5678, ready after 3 BUSY cycles → `mem_we`=1 for those 3 cycles only, `dm_rdata` unchanged, 4 stall cycles.
- **Watchdog:** `mem_ready` never asserted, TIMEOUT=16 → after 16 BUSY cycles `timeout_err`=1 (sticky), `if_rdata`=0, pipeline released. Repeat with ready on the 16th cycle → no error.
- **Mid-access reset:** `rst` in the 2nd BUSY cycle → `mem_req`=0 next cycle, state IDLE, flags 0.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch and data ports with global stall and watchdog
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_valid,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  timeout_err
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY_DM, BUSY_IF} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic if_served, dm_served, we_lat, busy, done, abort, fin;
  assign stall = (if_req & ~if_served) | (dm_req & ~dm_served);
  assign if_valid = if_served;
  assign dm_valid = dm_served;
  // data port wins: it belongs to the older instruction
  always_comb begin
    state_n = state;
    busy = state != IDLE;
    done = busy & mem_ready;
    abort = busy & ~mem_ready & (cnt == CW'(TIMEOUT - 1));
    fin = done | abort;
    mem_req = busy;
    mem_we = (state == BUSY_DM) & we_lat;
    if (state == IDLE)
      state_n = (dm_req & ~dm_served) ? BUSY_DM : (if_req & ~if_served) ? BUSY_IF : IDLE;
    else if (fin)
      state_n = IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      if_served <= 1'b0;
      dm_served <= 1'b0;
      we_lat <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!stall) begin
        if_served <= 1'b0;
        dm_served <= 1'b0;
      end
      if (state == IDLE && state_n == BUSY_DM) begin
        mem_addr <= dm_addr;
        mem_wdata <= dm_wdata;
        we_lat <= dm_we;
      end
      if (state == IDLE && state_n == BUSY_IF) mem_addr <= if_addr;
      if (busy) cnt <= fin ? '0 : cnt + 1'b1;
      if (abort) timeout_err <= 1'b1;
      // an aborted read returns zero; a write never touches dm_rdata
      if (fin && state == BUSY_DM) begin
        dm_served <= 1'b1;
        if (!we_lat) dm_rdata <= done ? mem_rdata : '0;
      end
      if (fin && state == BUSY_IF) begin
        if_served <= 1'b1;
        if_rdata <= done ? mem_rdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: table vectors plus random pipeline cycles checked against a transaction-level model
module tb_unified_mem_arbiter;
  localparam int TO = 16;
  logic clk = 1'b0, rst;
  logic if_req, if_valid, dm_req, dm_we, dm_valid, stall, mem_req, mem_we, mem_ready, timeout_err;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  typedef struct {
    logic dm; logic we; logic [31:0] daddr; logic [31:0] wdata; int wdm;
    logic ifr; logic [31:0] iaddr; int wif;
    int es; logic [31:0] eif; logic [31:0] edm; logic eterr;
  } vec_t;
  typedef struct {int w; logic we; logic [31:0] addr; logic [31:0] wdata;} acc_t;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  acc_t q[$];
  acc_t cur;
  vec_t tbl [12];
  int bcnt, checks, errors;
  logic [31:0] m_if, m_dm;
  logic m_terr;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic int busy_len(input int w);
    return w < TO ? w + 1 : TO;
  endfunction

  function automatic int rand_wait();
    int r = $urandom_range(0, 19);
    return r < 16 ? r % 4 : r == 16 ? 15 : r == 17 ? 14 : 99;
  endfunction

  // Transaction view: data access first, then fetch; each costs one grant cycle plus its busy cycles.
  task automatic model(inout vec_t v);
    v.es = 0;
    if (v.dm) begin
      v.es += 1 + busy_len(v.wdm);
      if (v.wdm >= TO) begin
        m_terr = 1'b1;
        if (!v.we) m_dm = 32'h0;
      end else if (v.we) ref_mem[v.daddr[9:2]] = v.wdata;
      else m_dm = ref_mem[v.daddr[9:2]];
    end
    if (v.ifr) begin
      v.es += 1 + busy_len(v.wif);
      if (v.wif >= TO) begin
        m_terr = 1'b1;
        m_if = 32'h0;
      end else m_if = ref_mem[v.iaddr[9:2]];
    end
    v.eif = m_if;
    v.edm = m_dm;
    v.eterr = m_terr;
  endtask

  // One pipeline cycle: hold requests until stall drops, acting as the memory meanwhile.
  task automatic run_pc(input vec_t v);
    int cyc = 0;
    logic prior, wr;
    logic [31:0] wa, wd;
    dm_req = v.dm; dm_we = v.we; dm_addr = v.daddr; dm_wdata = v.wdata;
    if_req = v.ifr; if_addr = v.iaddr;
    if (v.dm) q.push_back('{v.wdm, v.we, v.daddr, v.wdata});
    if (v.ifr) q.push_back('{v.wif, 1'b0, v.iaddr, 32'h0});
    #1;
    while (stall) begin
      if (mem_req) begin
        if (bcnt == 0) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_grant addr=%h t=%0t", mem_addr, $time);
            cur = '{99, 1'b0, mem_addr, mem_wdata};
          end else cur = q.pop_front();
        end
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_we", {31'h0, mem_we}, {31'h0, cur.we});
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
      end else chk("mem_we_idle", {31'h0, mem_we}, 32'h0);
      mem_ready = mem_req && bcnt == cur.w;
      mem_rdata = mem[mem_addr[9:2]];
      wr = mem_req & mem_ready & mem_we;
      wa = mem_addr; wd = mem_wdata;
      prior = mem_req;
      cyc++;
      if (cyc > 300) begin
        checks++; errors++;
        $display("FAIL stall_bound cycles=%0d t=%0t", cyc, $time);
        break;
      end
      @(posedge clk); #1;
      if (wr) mem[wa[9:2]] = wd;
      bcnt = (prior && mem_req) ? bcnt + 1 : 0;
    end
    mem_ready = 1'b0;
    chk("stall_cycles", cyc, v.es);
    chk("if_valid", {31'h0, if_valid}, {31'h0, v.ifr});
    chk("dm_valid", {31'h0, dm_valid}, {31'h0, v.dm});
    chk("if_rdata", if_rdata, v.eif);
    chk("dm_rdata", dm_rdata, v.edm);
    chk("timeout_err", {31'h0, timeout_err}, {31'h0, v.eterr});
    chk("missing_grant", q.size(), 0);
    q.delete();
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0;
    chk("flags_clear", {30'h0, if_valid, dm_valid}, 32'h0);
  endtask

  initial begin
    vec_t t;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | (i << 2);
    mem[8'h10] = 32'h2010_0005;
    mem[8'h11] = 32'h8C22_0000;
    mem[8'h40] = 32'hDEAD_BEEF;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    //          dm  we  daddr         wdata         wdm ifr iaddr     wif es  eif           edm           eterr
    tbl[0]  = '{0, 0, 32'h0,       32'h0,        0,  1, 32'h0,  0,  2,  32'hA500_0000, 32'h0,        0};
    tbl[1]  = '{0, 0, 32'h0,       32'h0,        0,  1, 32'h40, 0,  2,  32'h2010_0005, 32'h0,        0};
    tbl[2]  = '{1, 0, 32'h100,     32'h0,        0,  1, 32'h44, 0,  4,  32'h8C22_0000, 32'hDEAD_BEEF, 0};
    tbl[3]  = '{1, 1, 32'h200,     32'h1234_5678, 2, 0, 32'h0,  0,  4,  32'h8C22_0000, 32'hDEAD_BEEF, 0};
    tbl[4]  = '{1, 0, 32'h200,     32'h0,        1,  0, 32'h0,  0,  3,  32'h8C22_0000, 32'h1234_5678, 0};
    tbl[5]  = '{0, 0, 32'h0,       32'h0,        0,  1, 32'h40, 15, 17, 32'h2010_0005, 32'h1234_5678, 0};
    tbl[6]  = '{1, 1, 32'h300,     32'h0000_CAFE, 99, 0, 32'h0, 0,  17, 32'h2010_0005, 32'h1234_5678, 1};
    tbl[7]  = '{1, 0, 32'h300,     32'h0,        0,  0, 32'h0,  0,  2,  32'h2010_0005, 32'hA500_0300, 1};
    tbl[8]  = '{0, 0, 32'h0,       32'h0,        0,  1, 32'h44, 99, 17, 32'h0,        32'hA500_0300, 1};
    tbl[9]  = '{1, 0, 32'h100,     32'h0,        99, 1, 32'h40, 0,  19, 32'h2010_0005, 32'h0,        1};
    tbl[10] = '{0, 0, 32'h0,       32'h0,        0,  0, 32'h0,  0,  0,  32'h2010_0005, 32'h0,        1};
    tbl[11] = '{1, 1, 32'h44,      32'h1111_2222, 0, 1, 32'h44, 0,  4,  32'h1111_2222, 32'h0,        1};
    checks = 0; errors = 0; bcnt = 0;
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_mem_ctl", {28'h0, mem_req, mem_we, if_valid, dm_valid}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h1);
    rst = 1'b0;
    m_if = 32'h0; m_dm = 32'h0; m_terr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      t = tbl[i];
      model(t);
      run_pc(tbl[i]);
    end
    // reset lands in the second busy cycle of a read that would otherwise hang
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    @(posedge clk); #1;
    chk("mid_busy1", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    chk("mid_busy2", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_flags", {30'h0, if_valid, dm_valid}, 32'h0);
    chk("mid_rst_err", {31'h0, timeout_err}, 32'h0);
    chk("mid_rst_dm_rdata", dm_rdata, 32'h0);
    rst = 1'b0; dm_req = 1'b0;
    m_if = 32'h0; m_dm = 32'h0; m_terr = 1'b0; bcnt = 0; q.delete();
    t = '{1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0};
    model(t);
    chk("post_rst_model_cycles", t.es, 2);
    run_pc(t);
    for (int n = 0; n < 200; n++) begin
      t.dm = 1'($urandom_range(0, 1));
      t.we = 1'($urandom_range(0, 1));
      t.daddr = 32'($urandom_range(0, 15)) << 2;
      t.wdata = $urandom;
      t.wdm = rand_wait();
      t.ifr = 1'($urandom_range(0, 1));
      t.iaddr = 32'($urandom_range(0, 15)) << 2;
      t.wif = rand_wait();
      model(t);
      run_pc(t);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
